pulse_video_gen: RTL and testbench

//   Synthesises a sampled radar video stream from pulse descriptors (width, amplitude, PRI).

---
 rtl/pulse_video_gen_pkg.sv | 27 ++
 rtl/pulse_video_gen_if.sv | 14 +
 rtl/pulse_video_gen_desc_buf.sv | 36 +++
 rtl/pulse_video_gen.sv | 150 +++++++++++++++
 tb/tb_pulse_video_gen.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pulse_video_gen_pkg.sv
// Shared definitions for the pulse video generator: FSM state encoding,
// default widths and the field layout of the packed descriptor word.
package pulse_video_gen_pkg;

    localparam int DEFAULT_VIDEO_SIZE = 10;
    localparam int DEFAULT_CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Packed descriptor word is {pri, pa, pw}, pw in the least significant bits.
    function automatic int desc_width(int video_size, int cnt_w);
        return 2 * cnt_w + video_size;
    endfunction

    function automatic int pa_lsb(int cnt_w);
        return cnt_w;
    endfunction

    function automatic int pri_lsb(int video_size, int cnt_w);
        return cnt_w + video_size;
    endfunction

endpackage

// File: rtl/pulse_video_gen_if.sv
// Descriptor valid/ready channel into the pulse video generator.
interface pulse_video_gen_if #(
    parameter int VIDEO_SIZE = pulse_video_gen_pkg::DEFAULT_VIDEO_SIZE,
    parameter int CNT_W      = pulse_video_gen_pkg::DEFAULT_CNT_W
);
    logic                  desc_valid;
    logic                  desc_ready;
    logic [CNT_W-1:0]      desc_pw;
    logic [VIDEO_SIZE-1:0] desc_pa;
    logic [CNT_W-1:0]      desc_pri;

    modport master (output desc_valid, desc_pw, desc_pa, desc_pri, input desc_ready);
    modport slave  (input desc_valid, desc_pw, desc_pa, desc_pri, output desc_ready);
endinterface

// File: rtl/pulse_video_gen_desc_buf.sv
// One-entry holding register: accepts a word when empty, releases it on pop.
module pulse_video_gen_desc_buf #(
    parameter int W = 74
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         pop,
    output logic         full,
    output logic [W-1:0] data
);
    logic         full_reg;
    logic [W-1:0] data_reg;

    // Ready only when empty, so an accept and a pop can never coincide.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (enable) begin
            if (in_valid && !full_reg) begin
                full_reg <= 1'b1;
                data_reg <= in_data;
            end else if (pop) begin
                full_reg <= 1'b0;
            end
        end
    end

    assign in_ready = !full_reg;
    assign full     = full_reg;
    assign data     = data_reg;
endmodule

// File: rtl/pulse_video_gen.sv
// Turns pulse descriptors (width, amplitude, PRI) into a sampled video stream
// with the time of arrival and pulse count of the most recent pulse.
module pulse_video_gen
    import pulse_video_gen_pkg::*;
#(
    parameter int VIDEO_SIZE = DEFAULT_VIDEO_SIZE,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    pulse_video_gen_if.slave      desc,
    input  logic [VIDEO_SIZE-1:0] baseline,
    output logic [VIDEO_SIZE-1:0] video,
    output logic                  pulse_active,
    output logic [CNT_W-1:0]      toa,
    output logic [CNT_W-1:0]      pc
);
    localparam int DESC_W  = desc_width(VIDEO_SIZE, CNT_W);
    localparam int PA_LSB  = pa_lsb(CNT_W);
    localparam int PRI_LSB = pri_lsb(VIDEO_SIZE, CNT_W);

    logic                  hold_full;
    logic                  pop;
    logic [DESC_W-1:0]     hold_data;
    logic [CNT_W-1:0]      hold_pw;
    logic [VIDEO_SIZE-1:0] hold_pa;
    logic [CNT_W-1:0]      hold_pri;
    logic [CNT_W-1:0]      pri_load;

    state_t                state_reg,  state_next;
    logic [CNT_W-1:0]      time_reg,   time_next;
    logic [CNT_W-1:0]      pw_cnt_reg, pw_cnt_next;
    logic [CNT_W-1:0]      pri_cnt_reg, pri_cnt_next;
    logic [VIDEO_SIZE-1:0] video_reg,  video_next;
    logic                  active_reg, active_next;
    logic [CNT_W-1:0]      toa_reg,    toa_next;
    logic [CNT_W-1:0]      pc_reg,     pc_next;
    logic                  start;

    pulse_video_gen_desc_buf #(.W(DESC_W)) u_desc_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .in_valid (desc.desc_valid),
        .in_ready (desc.desc_ready),
        .in_data  ({desc.desc_pri, desc.desc_pa, desc.desc_pw}),
        .pop      (pop),
        .full     (hold_full),
        .data     (hold_data)
    );

    assign hold_pw  = hold_data[0 +: CNT_W];
    assign hold_pa  = hold_data[PA_LSB +: VIDEO_SIZE];
    assign hold_pri = hold_data[PRI_LSB +: CNT_W];

    // max(pri, pw+1) - 1 rewritten as max(pri-1, pw): same value, and pw+1 can
    // no longer overflow CNT_W bits.
    assign pri_load = (hold_pri > hold_pw) ? (hold_pri - CNT_W'(1)) : hold_pw;

    always_comb begin
        state_next   = state_reg;
        time_next    = time_reg;
        pw_cnt_next  = pw_cnt_reg;
        pri_cnt_next = pri_cnt_reg;
        video_next   = video_reg;
        active_next  = active_reg;
        toa_next     = toa_reg;
        pc_next      = pc_reg;
        start        = 1'b0;
        pop          = 1'b0;

        if (enable) begin
            time_next = time_reg + CNT_W'(1);
            case (state_reg)
                ST_IDLE: begin
                    video_next = baseline;
                    start      = hold_full;
                end
                ST_PULSE: begin
                    pri_cnt_next = pri_cnt_reg - CNT_W'(1);
                    if (pw_cnt_reg == '0) begin
                        video_next  = baseline;
                        active_next = 1'b0;
                        state_next  = ST_GAP;
                    end else begin
                        pw_cnt_next = pw_cnt_reg - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    video_next = baseline;
                    if (pri_cnt_reg == '0) begin
                        start = hold_full;
                        if (!hold_full) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        pri_cnt_next = pri_cnt_reg - CNT_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase

            if (start) begin
                pop          = 1'b1;
                pri_cnt_next = pri_load;
                // A zero-width descriptor only spends its PRI as baseline.
                if (hold_pw == '0) begin
                    state_next  = ST_GAP;
                    video_next  = baseline;
                    active_next = 1'b0;
                end else begin
                    state_next  = ST_PULSE;
                    video_next  = hold_pa;
                    active_next = 1'b1;
                    toa_next    = time_reg;
                    pc_next     = pc_reg + CNT_W'(1);
                    pw_cnt_next = hold_pw - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            time_reg    <= '0;
            pw_cnt_reg  <= '0;
            pri_cnt_reg <= '0;
            video_reg   <= '0;
            active_reg  <= 1'b0;
            toa_reg     <= '0;
            pc_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            time_reg    <= time_next;
            pw_cnt_reg  <= pw_cnt_next;
            pri_cnt_reg <= pri_cnt_next;
            video_reg   <= video_next;
            active_reg  <= active_next;
            toa_reg     <= toa_next;
            pc_reg      <= pc_next;
        end
    end

    assign video        = video_reg;
    assign pulse_active = active_reg;
    assign toa          = toa_reg;
    assign pc           = pc_reg;
endmodule

// File: tb/tb_pulse_video_gen.sv
// Directed bench for pulse_video_gen: per-cycle vector table plus reset and
// counter-wrap sequences (the wrap case uses a 4-bit counter instance).
module tb_pulse_video_gen;

    typedef struct {
        logic        en;
        logic        valid;
        logic [31:0] pw;
        logic [9:0]  pa;
        logic [31:0] pri;
        logic [9:0]  base;
        logic [9:0]  exp_video;
        logic        exp_act;
        logic        exp_rdy;
        logic [31:0] exp_toa;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        reset4_n;
    logic        enable;
    logic [9:0]  baseline;
    logic [9:0]  video,  video4;
    logic        pulse_active, active4;
    logic [31:0] toa, pc;
    logic [3:0]  toa4, pc4;

    always #5 clock = ~clock;

    pulse_video_gen_if #(.VIDEO_SIZE(10), .CNT_W(32)) dif ();
    pulse_video_gen_if #(.VIDEO_SIZE(10), .CNT_W(4))  dif4 ();

    pulse_video_gen #(.VIDEO_SIZE(10), .CNT_W(32)) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .desc         (dif),
        .baseline     (baseline),
        .video        (video),
        .pulse_active (pulse_active),
        .toa          (toa),
        .pc           (pc)
    );

    pulse_video_gen #(.VIDEO_SIZE(10), .CNT_W(4)) u_dut4 (
        .clock        (clock),
        .reset_n      (reset4_n),
        .enable       (1'b1),
        .desc         (dif4),
        .baseline     (baseline),
        .video        (video4),
        .pulse_active (active4),
        .toa          (toa4),
        .pc           (pc4)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void add(input int n, input logic en, input logic v, input logic [31:0] pw,
                                input logic [9:0] pa, input logic [31:0] pri, input logic [9:0] b,
                                input logic [9:0] vid, input logic act, input logic rdy,
                                input logic [31:0] t, input logic [31:0] p);
        for (int i = 0; i < n; i++) vecs.push_back('{en, v, pw, pa, pri, b, vid, act, rdy, t, p});
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pw, input logic [9:0] pa, input logic [31:0] pri);
        dif.desc_valid = v;
        dif.desc_pw    = pw;
        dif.desc_pa    = pa;
        dif.desc_pri   = pri;
    endtask

    initial begin
        // single pulse pw=4 pa=600 pri=10, accepted so it starts at time 3
        add(2, 1,0,0,0,0,5,      5,0,1,0,0);
        add(1, 1,1,4,600,10,5,   5,0,0,0,0);
        add(4, 1,0,0,0,0,5,      600,1,1,3,1);
        add(7, 1,0,0,0,0,5,      5,0,1,3,1);
        // zero-width descriptor (pri 4) then pw=1 pri=2
        add(1, 1,1,0,900,4,5,    5,0,0,3,1);
        add(1, 1,1,1,700,2,5,    5,0,1,3,1);
        add(1, 1,1,1,700,2,5,    5,0,0,3,1);
        add(2, 1,0,0,0,0,5,      5,0,0,3,1);
        add(1, 1,0,0,0,0,5,      700,1,1,19,2);
        add(1, 1,0,0,0,0,5,      5,0,1,19,2);
        add(2, 1,0,0,0,0,8,      8,0,1,19,2);
        // pw=5 pri=3 -> pri_eff 6; amplitude below baseline
        add(1, 1,1,5,3,3,8,      8,0,0,19,2);
        add(1, 1,1,5,3,3,8,      3,1,1,24,3);
        add(1, 1,1,5,3,3,8,      3,1,0,24,3);
        add(3, 1,0,0,0,0,8,      3,1,0,24,3);
        add(1, 1,0,0,0,0,8,      8,0,0,24,3);
        add(5, 1,0,0,0,0,8,      3,1,1,30,4);
        add(2, 1,0,0,0,0,8,      8,0,1,30,4);
        // three back-to-back pw=2 pri=6 with desc_valid held high
        add(1, 1,1,2,100,6,8,    8,0,0,30,4);
        add(1, 1,1,2,200,6,8,    100,1,1,38,5);
        add(1, 1,1,2,200,6,8,    100,1,0,38,5);
        add(4, 1,1,2,300,6,8,    8,0,0,38,5);
        add(1, 1,1,2,300,6,8,    200,1,1,44,6);
        add(1, 1,1,2,300,6,8,    200,1,0,44,6);
        add(4, 1,0,0,0,0,8,      8,0,0,44,6);
        add(2, 1,0,0,0,0,8,      300,1,1,50,7);
        add(5, 1,0,0,0,0,8,      8,0,1,50,7);
        // enable low for 7 cycles mid-pulse, with a descriptor offered meanwhile
        add(1, 1,1,4,500,8,8,    8,0,0,50,7);
        add(2, 1,0,0,0,0,8,      500,1,1,58,8);
        add(7, 0,1,1,50,1,9,     500,1,1,58,8);
        add(2, 1,0,0,0,0,8,      500,1,1,58,8);
        add(5, 1,0,0,0,0,8,      8,0,1,58,8);
        add(1, 1,1,1,77,1,8,     8,0,0,58,8);
        add(1, 1,0,0,0,0,8,      77,1,1,68,9);
        add(2, 1,0,0,0,0,8,      8,0,1,68,9);

        reset_n  = 1'b0;
        reset4_n = 1'b0;
        enable   = 1'b1;
        baseline = 10'd5;
        drive(1'b0, 0, 0, 0);
        dif4.desc_valid = 1'b0;
        dif4.desc_pw    = 4'd1;
        dif4.desc_pa    = 10'd10;
        dif4.desc_pri   = 4'd2;
        repeat (3) cyc();
        check("reset_video", video, 0);
        check("reset_active", pulse_active, 0);
        check("reset_toa", toa, 0);
        check("reset_pc", pc, 0);
        check("reset_ready", dif.desc_ready, 1);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            enable   = vecs[i].en;
            baseline = vecs[i].base;
            drive(vecs[i].valid, vecs[i].pw, vecs[i].pa, vecs[i].pri);
            cyc();
            check($sformatf("row%0d_video", i + 1), video, vecs[i].exp_video);
            check($sformatf("row%0d_active", i + 1), pulse_active, vecs[i].exp_act);
            check($sformatf("row%0d_ready", i + 1), dif.desc_ready, vecs[i].exp_rdy);
            check($sformatf("row%0d_toa", i + 1), toa, vecs[i].exp_toa);
            check($sformatf("row%0d_pc", i + 1), pc, vecs[i].exp_pc);
        end

        // reset mid-pulse with the holding register full
        enable = 1'b1;
        baseline = 10'd8;
        drive(1'b1, 6, 400, 10); cyc();
        drive(1'b1, 6, 401, 10); cyc();
        cyc();
        drive(1'b0, 0, 0, 0); cyc();
        check("prerst_video", video, 400);
        check("prerst_ready", dif.desc_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_video", video, 0);
        check("async_rst_active", pulse_active, 0);
        check("async_rst_toa", toa, 0);
        check("async_rst_pc", pc, 0);
        check("async_rst_ready", dif.desc_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cyc();
            check($sformatf("postrst%0d_video", i), video, 8);
            check($sformatf("postrst%0d_active", i), pulse_active, 0);
        end
        check("postrst_pc", pc, 0);

        // 4-bit counters: pulse every 2 cycles, toa and pc wrap past 15
        reset4_n = 1'b1;
        dif4.desc_valid = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            cyc();
            if (e % 2 == 0) begin
                check($sformatf("wrap_e%0d_active", e), active4, 1);
                check($sformatf("wrap_e%0d_pc", e), pc4, (e / 2) % 16);
                check($sformatf("wrap_e%0d_toa", e), toa4, (e - 1) % 16);
            end else begin
                check($sformatf("wrap_e%0d_active", e), active4, 0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
